// File: rtl/pixel_streamer.sv
// pixel_streamer: captures one IX x IY raster frame into internal RAM and
// replays it as a throttleable valid/pixel stream with coordinates.
// Read path is two registers deep: RAM data register, then output register.
module pixel_streamer #(
    parameter int I_F_BW = 8,
    parameter int IX     = 28,
    parameter int IY     = 28
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_wr_valid,
    input  logic [I_F_BW-1:0]       i_wr_pixel,
    input  logic                    i_start,
    input  logic                    i_clear,
    input  logic                    i_out_ready,
    output logic                    o_out_valid,
    output logic [I_F_BW-1:0]       o_out_pixel,
    output logic [$clog2(IX)-1:0]   o_x,
    output logic [$clog2(IY)-1:0]   o_y,
    output logic                    o_frame_done,
    output logic                    o_frame_loaded,
    output logic                    o_busy
);

    localparam int NPIX = IX * IY;
    localparam int PW   = $clog2(NPIX);
    localparam int XW   = $clog2(IX);
    localparam int YW   = $clog2(IY);

    localparam logic [PW-1:0] LAST_IDX = PW'(NPIX - 1);
    localparam logic [XW-1:0] LAST_X   = XW'(IX - 1);
    localparam logic [YW-1:0] LAST_Y   = YW'(IY - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FULL   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                w_wr_en;
    logic                w_rd_issue;
    logic                w_start;

    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic                r_frame_loaded;

    // Frame storage; deliberately not reset.
    logic [I_F_BW-1:0]   r_mem [0:NPIX-1];
    logic [I_F_BW-1:0]   r_rd_data;

    // Read-in-flight stage, aligned with r_rd_data.
    logic                r_rd_valid;
    logic [XW-1:0]       r_rd_x;
    logic [YW-1:0]       r_rd_y;
    logic                r_rd_last;

    // Output stage.
    logic                r_out_valid;
    logic [I_F_BW-1:0]   r_out_pixel;
    logic [XW-1:0]       r_out_x;
    logic [YW-1:0]       r_out_y;
    logic                r_frame_done;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle write/read/start strobes; clear wins over everything.
    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_rd_issue   = 1'b0;
        w_start      = 1'b0;
        if (i_clear) begin
            w_state_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (i_wr_valid) begin
                        w_wr_en = 1'b1;
                        if (r_wr_ptr == LAST_IDX) begin
                            w_state_next = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (i_start) begin
                        w_start      = 1'b1;
                        w_state_next = S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (i_out_ready) begin
                        w_rd_issue = 1'b1;
                        if (r_rd_ptr == LAST_IDX) begin
                            w_state_next = S_FULL;
                        end
                    end
                end
                default: begin
                    w_state_next = S_LOAD;
                end
            endcase
        end
    end

    // Write pointer, read pointer, raster coordinates and loaded flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_frame_loaded <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r_frame_loaded <= 1'b0;
        end else begin
            if (w_wr_en) begin
                if (r_wr_ptr == LAST_IDX) begin
                    r_wr_ptr       <= '0;
                    r_frame_loaded <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
            end
            if (w_start) begin
                r_rd_ptr <= '0;
                r_x      <= '0;
                r_y      <= '0;
            end else if (w_rd_issue) begin
                if (r_rd_ptr == LAST_IDX) begin
                    r_rd_ptr <= '0;
                end else begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (r_x == LAST_X) begin
                    r_x <= '0;
                    if (r_y == LAST_Y) begin
                        r_y <= '0;
                    end else begin
                        r_y <= r_y + YW'(1);
                    end
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    // RAM write port and registered read port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_pixel;
        end
        if (w_rd_issue) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Tag travelling with the RAM read: valid, coordinates, last-pixel flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_x    <= r_x;
                r_rd_y    <= r_y;
                r_rd_last <= (r_rd_ptr == LAST_IDX);
            end
        end
    end

    // Output register; a clear discards whatever read is still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_pixel  <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_frame_done <= 1'b0;
        end else if (i_clear) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= r_rd_valid;
            r_frame_done <= r_rd_valid & r_rd_last;
            if (r_rd_valid) begin
                r_out_pixel <= r_rd_data;
                r_out_x     <= r_rd_x;
                r_out_y     <= r_rd_y;
            end
        end
    end

    assign o_out_valid    = r_out_valid;
    assign o_out_pixel    = r_out_pixel;
    assign o_x            = r_out_x;
    assign o_y            = r_out_y;
    assign o_frame_done   = r_frame_done;
    assign o_frame_loaded = r_frame_loaded;
    assign o_busy         = (r_state == S_STREAM) | r_rd_valid | r_out_valid;

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: a frame-level reference model
// compared every cycle, plus literal expectations on latency, ordering,
// replay gap, throttle span, abort and reset behaviour.
module tb_pixel_streamer;

    localparam int I_F_BW = 8;
    localparam int IX     = 28;
    localparam int IY     = 28;
    localparam int N      = IX * IY;

    logic                  clk        = 1'b0;
    logic                  reset_n    = 1'b0;
    logic                  i_wr_valid = 1'b0;
    logic [I_F_BW-1:0]     i_wr_pixel = '0;
    logic                  i_start    = 1'b0;
    logic                  i_clear    = 1'b0;
    logic                  i_out_ready = 1'b0;
    logic                  o_out_valid;
    logic [I_F_BW-1:0]     o_out_pixel;
    logic [$clog2(IX)-1:0] o_x;
    logic [$clog2(IY)-1:0] o_y;
    logic                  o_frame_done;
    logic                  o_frame_loaded;
    logic                  o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    pixel_streamer #(.I_F_BW(I_F_BW), .IX(IX), .IY(IY)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_wr_valid     (i_wr_valid),
        .i_wr_pixel     (i_wr_pixel),
        .i_start        (i_start),
        .i_clear        (i_clear),
        .i_out_ready    (i_out_ready),
        .o_out_valid    (o_out_valid),
        .o_out_pixel    (o_out_pixel),
        .o_x            (o_x),
        .o_y            (o_y),
        .o_frame_done   (o_frame_done),
        .o_frame_loaded (o_frame_loaded),
        .o_busy         (o_busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_LOAD, M_FULL, M_STREAM} phase_t;
    phase_t          m_phase   = M_LOAD;
    logic [I_F_BW-1:0] m_mem [N];
    int              m_wr      = 0;
    int              m_rd      = 0;
    bit              m_loaded  = 1'b0;
    bit              m_p1_v    = 1'b0;
    int              m_p1_idx  = 0;
    logic [I_F_BW-1:0] m_p1_pix = '0;
    bit              m_out_v   = 1'b0;
    int              m_out_idx = 0;
    logic [I_F_BW-1:0] m_out_pix = '0;

    task automatic model_step();
        if (!reset_n) begin
            m_phase = M_LOAD; m_wr = 0; m_rd = 0; m_loaded = 1'b0;
            m_p1_v = 1'b0; m_out_v = 1'b0;
        end else begin
            m_out_v = m_p1_v && !i_clear;
            if (m_p1_v) begin
                m_out_idx = m_p1_idx;
                m_out_pix = m_p1_pix;
            end
            m_p1_v = 1'b0;
            if (i_clear) begin
                m_phase = M_LOAD; m_wr = 0; m_rd = 0; m_loaded = 1'b0;
            end else begin
                case (m_phase)
                    M_LOAD: if (i_wr_valid) begin
                        m_mem[m_wr] = i_wr_pixel;
                        if (m_wr == N - 1) begin
                            m_phase = M_FULL; m_loaded = 1'b1; m_wr = 0;
                        end else m_wr++;
                    end
                    M_FULL: if (i_start) begin
                        m_phase = M_STREAM; m_rd = 0;
                    end
                    M_STREAM: if (i_out_ready) begin
                        m_p1_v = 1'b1; m_p1_idx = m_rd; m_p1_pix = m_mem[m_rd];
                        if (m_rd == N - 1) begin
                            m_phase = M_FULL; m_rd = 0;
                        end else m_rd++;
                    end
                    default: m_phase = M_LOAD;
                endcase
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    task automatic compare_step();
        chk("valid", o_out_valid, m_out_v);
        chk("frame_done", o_frame_done, (m_out_v && m_out_idx == N - 1));
        chk("frame_loaded", o_frame_loaded, m_loaded);
        chk("busy", o_busy, (m_phase == M_STREAM || m_p1_v || m_out_v));
        if (m_out_v) begin
            chk("pixel", o_out_pixel, m_out_pix);
            chk("x", o_x, m_out_idx % IX);
            chk("y", o_y, m_out_idx / IX);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (checking) compare_step();
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [I_F_BW-1:0] exp_pix(input int mode, input int k);
        logic [7:0] v;
        v = k[7:0];
        return (mode == 0) ? v : (8'd255 - v);
    endfunction

    function automatic logic ready_for(input int rmode, input int c);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return c[0];
        return ($urandom_range(0, 3) != 0);
    endfunction

    task automatic load_frame(input int mode, input int start_at);
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                i_wr_valid = 1'b0; i_start = 1'b0; i_wr_pixel = 8'($urandom);
            end
            @(negedge clk);
            if (k == N - 1) chk("loaded_before_last_write", o_frame_loaded, 0);
            if (start_at >= 0 && k == start_at + 3) chk("start_ignored_in_load", o_out_valid, 0);
            i_wr_valid = 1'b1;
            i_wr_pixel = exp_pix(mode, k);
            i_start    = (k == start_at);
        end
        @(negedge clk);
        i_wr_valid = 1'b0; i_start = 1'b0;
        chk("loaded_after_last_write", o_frame_loaded, 1);
    endtask

    task automatic run_stream(input int rmode, input int mode, input int nframes,
                              input int clear_at, input bit poke);
        int c = 0, seen = 0, first_c = -1, last_c = -1, done_c = -1, second_c = -1, span;
        bit fin = 1'b0;
        @(negedge clk);
        i_start = 1'b1;
        i_out_ready = ready_for(rmode, 0);
        while (!fin && c < 4000) begin
            @(negedge clk);
            c++;
            i_start = 1'b0;
            if (o_out_valid) begin
                chk("seq_pixel", o_out_pixel, exp_pix(mode, seen % N));
                if (seen == 0) first_c = c;
                if (seen == N) second_c = c;
                last_c = c;
                seen++;
                if (o_frame_done) begin
                    chk("done_at_last_index", (seen - 1) % N, N - 1);
                    chk("done_x", o_x, IX - 1);
                    chk("done_y", o_y, IY - 1);
                    if (done_c < 0) done_c = c;
                    if (seen < nframes * N) i_start = 1'b1;
                end
                if (clear_at >= 0 && seen == clear_at + 1) begin
                    i_clear = 1'b1;
                    @(negedge clk);
                    i_clear = 1'b0;
                    chk("abort_valid", o_out_valid, 0);
                    chk("abort_loaded", o_frame_loaded, 0);
                    chk("abort_busy", o_busy, 0);
                    fin = 1'b1;
                end
            end else if (seen == nframes * N) begin
                chk("busy_after_last", o_busy, 0);
                chk("busy_fall_delay", c - last_c, 1);
                fin = 1'b1;
            end
            if (poke && c == 50) i_start = 1'b1;
            i_out_ready = ready_for(rmode, c);
        end
        i_out_ready = 1'b0;
        i_start     = 1'b0;
        chk("stream_finished_in_budget", fin, 1);
        if (clear_at < 0) chk("pixel_count", seen, nframes * N);
        if (rmode == 0 && clear_at < 0) chk("first_pixel_latency", first_c, 3);
        if (rmode == 1) begin
            span = last_c - first_c + 1;
            chk("throttle_span_in_window", (span >= 1566 && span <= 1570), 1);
        end
        if (nframes == 2) chk("replay_gap", second_c - done_c, 3);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nv;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        chk("reset_valid", o_out_valid, 0);
        chk("reset_pixel", o_out_pixel, 0);
        chk("reset_x", o_x, 0);
        chk("reset_y", o_y, 0);
        chk("reset_done", o_frame_done, 0);
        chk("reset_loaded", o_frame_loaded, 0);
        chk("reset_busy", o_busy, 0);
        reset_n = 1'b1;

        // Start with nothing loaded must not stream.
        @(negedge clk); i_start = 1'b1; i_out_ready = 1'b1;
        @(negedge clk); i_start = 1'b0;
        nv = 0;
        repeat (10) begin @(negedge clk); if (o_out_valid) nv++; end
        chk("no_stream_when_unloaded", nv, 0);
        i_out_ready = 1'b0;

        // Load with a start pulse after 100 writes, then junk writes in FULL.
        load_frame(0, 100);
        repeat (10) begin @(negedge clk); i_wr_valid = 1'b1; i_wr_pixel = 8'($urandom); end
        @(negedge clk); i_wr_valid = 1'b0;

        run_stream(0, 0, 1, -1, 1'b1);   // basic, start poked mid-stream
        run_stream(1, 0, 1, -1, 1'b0);   // alternating ready
        run_stream(2, 0, 1, -1, 1'b0);   // random ready
        run_stream(0, 0, 2, -1, 1'b0);   // replay on frame_done
        run_stream(0, 0, 1, 300, 1'b0);  // abort after pixel 300

        // Clear concurrent with a write drops that write; then load new frame.
        @(negedge clk); i_wr_valid = 1'b1; i_wr_pixel = 8'hAA; i_clear = 1'b1;
        @(negedge clk); i_wr_valid = 1'b0; i_clear = 1'b0;
        load_frame(1, -1);
        run_stream(0, 1, 1, -1, 1'b0);

        // Asynchronous reset in the middle of a stream.
        @(negedge clk); i_start = 1'b1; i_out_ready = 1'b1;
        @(negedge clk); i_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("streaming_before_reset", o_out_valid, 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_valid", o_out_valid, 0);
        chk("async_reset_pixel", o_out_pixel, 0);
        chk("async_reset_x", o_x, 0);
        chk("async_reset_y", o_y, 0);
        chk("async_reset_done", o_frame_done, 0);
        chk("async_reset_loaded", o_frame_loaded, 0);
        chk("async_reset_busy", o_busy, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        nv = 0;
        repeat (10) begin @(negedge clk); if (o_out_valid) nv++; end
        chk("no_stream_after_reset", nv, 0);
        i_out_ready = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
